// File: rtl/alu_arbiter_if.sv
// Bus bundle between two requesters, the arbiter, a shared ALU and the response consumer.
// The slave modport is the arbiter's view; master is the environment's.
interface alu_arbiter_if;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [3:0]  req0_op, req1_op;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  alu_ctr;
    logic [31:0] alu_a, alu_b;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        rsp_valid, rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_zero;

    modport slave (
        input  req0_valid, req1_valid, req0_op, req1_op,
        input  req0_a, req0_b, req1_a, req1_b,
        input  alu_result, alu_zero, rsp_ready,
        output req0_ready, req1_ready, alu_ctr, alu_a, alu_b,
        output rsp_valid, rsp_id, rsp_result, rsp_zero
    );

    modport master (
        output req0_valid, req1_valid, req0_op, req1_op,
        output req0_a, req0_b, req1_a, req1_b,
        output alu_result, alu_zero, rsp_ready,
        input  req0_ready, req1_ready, alu_ctr, alu_a, alu_b,
        input  rsp_valid, rsp_id, rsp_result, rsp_zero
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; one operation in flight,
// mul/div held in EXEC for MULDIV_HOLD cycles, result captured and handed off in RESP.
module alu_arbiter #(
    parameter int unsigned MULDIV_HOLD = 3
) (
    input logic         clk,
    input logic         reset,
    alu_arbiter_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;
    localparam logic [3:0] HOLD = 4'(MULDIV_HOLD);

    logic [1:0]  state_q, state_d;
    logic        last_q, last_d;
    logic        id_q, id_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] result_q, result_d;
    logic        zero_q, zero_d;

    logic        grant;
    logic        xfer;
    logic [3:0]  sel_op;

    // Contention goes to whoever did not win last; a lone requester always wins.
    always_comb begin
        if (bus.req0_valid && bus.req1_valid) grant = ~last_q;
        else                                  grant = bus.req1_valid;
        xfer   = (state_q == IDLE) && (bus.req0_valid || bus.req1_valid) && !reset;
        sel_op = grant ? bus.req1_op : bus.req0_op;
    end

    assign bus.req0_ready = xfer & ~grant;
    assign bus.req1_ready = xfer & grant;

    always_comb begin
        state_d  = state_q;
        last_d   = last_q;
        id_d     = id_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    last_d  = grant;
                    id_d    = grant;
                    op_d    = sel_op;
                    a_d     = grant ? bus.req1_a : bus.req0_a;
                    b_d     = grant ? bus.req1_b : bus.req0_b;
                    cnt_d   = (sel_op == 4'd8 || sel_op == 4'd9) ? HOLD : 4'd1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    result_d = bus.alu_result;
                    zero_d   = bus.alu_zero;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            last_q   <= 1'b1;
            id_q     <= 1'b0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            id_q     <= id_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end

    assign bus.alu_ctr    = op_q;
    assign bus.alu_a      = a_q;
    assign bus.alu_b      = b_q;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_result = result_q;
    assign bus.rsp_zero   = zero_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed plus randomized bench for alu_arbiter with a behavioural shared ALU and a
// transaction-level expectation of grant order, latency and captured result.
module tb_alu_arbiter;
    localparam int HOLD = 3;

    logic clk;
    logic reset;
    int   vecs = 0;
    int   errs = 0;
    int   last = 1;

    alu_arbiter_if bus();

    alu_arbiter #(.MULDIV_HOLD(HOLD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {zero, result}; unknown codes yield 0.
    function automatic logic [32:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        case (op)
            4'd0:    r = a & b;
            4'd1:    r = a | b;
            4'd2:    r = a + b;
            4'd3:    r = {31'b0, a == b};
            4'd4:    r = {31'b0, a <= b};
            4'd5:    r = {31'b0, a >= b};
            4'd6:    r = a - b;
            4'd7:    r = {31'b0, a > b};
            4'd8:    r = a * b;
            4'd9:    r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            4'd10:   r = {31'b0, a != b};
            4'd12:   r = ~(a | b);
            default: r = 32'd0;
        endcase
        return {r == 32'd0, r};
    endfunction

    always_comb {bus.alu_zero, bus.alu_result} = alu_ref(bus.alu_ctr, bus.alu_a, bus.alu_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_ready(input string tag);
        chk({tag, "_r0"}, 32'(bus.req0_ready), 32'd0);
        chk({tag, "_r1"}, 32'(bus.req1_ready), 32'd0);
    endtask

    // Called just after a falling edge with the arbiter in IDLE; returns the same way.
    task automatic txn(input bit v0, input bit v1,
                       input logic [3:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                       input logic [3:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                       input int rdly);
        int          g;
        int          lat;
        logic [3:0]  eop;
        logic [31:0] ea, eb;
        logic [32:0] er;
        bus.req0_valid = v0; bus.req0_op = op0; bus.req0_a = a0; bus.req0_b = b0;
        bus.req1_valid = v1; bus.req1_op = op1; bus.req1_a = a1; bus.req1_b = b1;
        bus.rsp_ready  = (rdly == 0);
        #1;
        g   = (v0 && v1) ? 1 - last : (v1 ? 1 : 0);
        chk("grant_r0", 32'(bus.req0_ready), 32'(g == 0));
        chk("grant_r1", 32'(bus.req1_ready), 32'(g == 1));
        eop = g ? op1 : op0;
        ea  = g ? a1 : a0;
        eb  = g ? b1 : b0;
        er  = alu_ref(eop, ea, eb);
        lat = (eop == 4'd8 || eop == 4'd9) ? HOLD + 1 : 2;
        last = g;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            bus.req0_op = 4'($urandom); bus.req0_a = $urandom; bus.req0_b = $urandom;
            bus.req1_op = 4'($urandom); bus.req1_a = $urandom; bus.req1_b = $urandom;
            #1;
            chk("rsp_valid_lat", 32'(bus.rsp_valid), 32'(k == lat));
            chk_idle_ready("busy");
            if (k < lat) begin
                chk("alu_ctr", 32'(bus.alu_ctr), 32'(eop));
                chk("alu_a", bus.alu_a, ea);
                chk("alu_b", bus.alu_b, eb);
            end
        end
        chk("rsp_id", 32'(bus.rsp_id), 32'(g));
        chk("rsp_result", bus.rsp_result, er[31:0]);
        chk("rsp_zero", 32'(bus.rsp_zero), 32'(er[32]));
        for (int d = 0; d < rdly; d++) begin
            @(negedge clk); #1;
            chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
            chk("bp_result", bus.rsp_result, er[31:0]);
            chk_idle_ready("bp");
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b0;
        #1;
        chk("post_hs_valid", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_op = 4'd0; bus.req1_op = 4'd0;
        bus.req0_a = '0; bus.req0_b = '0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp_ready = 1'b0;
        reset = 1'b0;
        #1 reset = 1'b1;
        bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
        bus.req0_op = 4'd2; bus.req0_a = 32'd5; bus.req0_b = 32'd7;
        #2;
        chk_idle_ready("rst");
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_result", bus.rsp_result, 32'd0);
        chk("rst_rsp_zero", 32'(bus.rsp_zero), 32'd0);
        chk("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
        chk("rst_alu_ctr", 32'(bus.alu_ctr), 32'd0);
        chk("rst_alu_a", bus.alu_a, 32'd0);
        chk("rst_alu_b", bus.alu_b, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;

        // Single add straight out of reset, then mul hold, backpressure, undefined op.
        txn(1, 0, 4'd2, 32'd5, 32'd7, 4'd0, 32'd0, 32'd0, 0);
        txn(0, 1, 4'd0, 32'd0, 32'd0, 4'd8, 32'd3, 32'd4, 0);
        txn(1, 0, 4'd2, 32'hFFFF_FFFF, 32'd1, 4'd0, 32'd0, 32'd0, 5);
        txn(1, 0, 4'd13, 32'd1, 32'd1, 4'd0, 32'd0, 32'd0, 0);

        // Reset pulse during a div in EXEC discards it.
        bus.req1_valid = 1'b1; bus.req1_op = 4'd9; bus.req1_a = 32'd100; bus.req1_b = 32'd7;
        #1;
        chk("div_grant", 32'(bus.req1_ready), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("midrst_ctr", 32'(bus.alu_ctr), 32'd0);
        chk_idle_ready("midrst");
        @(negedge clk);
        reset = 1'b0;
        bus.req1_valid = 1'b0;
        last = 1;
        for (int k = 0; k < HOLD + 3; k++) begin
            @(negedge clk); #1;
            chk("no_rsp_after_rst", 32'(bus.rsp_valid), 32'd0);
        end

        // Contention with both held valid alternates 0,1,0,1 starting from requester 0.
        for (int i = 0; i < 4; i++)
            txn(1, 1, 4'd6, 32'd9, 32'd9, 4'd1, 32'hF0, 32'h0F, 0);

        for (int i = 0; i < 40; i++) begin
            int vv;
            vv = $urandom_range(1, 3);
            txn(vv[0], vv[1],
                4'($urandom_range(0, 15)), $urandom_range(0, 300), $urandom,
                4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 20),
                $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
